// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: write-then-read memory BIST that compares write and read signatures.
module mem_bist_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [7:0]        LFSR_IN,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [7:0]        MEM_RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [7:0]        SIG
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, FIN} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d, rv_q, rv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d, sig_q, sig_d, wsig_q, wsig_d, rsig_q, rsig_d, rd_q, rd_d;
  logic acc, last;
  function automatic logic [7:0] sig_next(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ d;
  endfunction
  assign acc = req_q & MEM_ACK;
  assign last = addr_q == LAST;
  // Read data is registered before folding into the signature; READ spends one
  // extra cycle with MEM_REQ low so the last byte lands before CHECK compares.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    sig_d   = sig_q;
    wsig_d  = wsig_q;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    rsig_d  = rv_q ? sig_next(rsig_q, rd_q) : rsig_q;
    case (state_q)
      IDLE, FIN: if (START) begin
        state_d = WRITE;
        wsig_d  = '0;
        rsig_d  = '0;
        addr_d  = '0;
        we_d    = 1'b1;
        req_d   = 1'b1;
        wdata_d = LFSR_IN;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
      WRITE: if (acc) begin
        wsig_d  = sig_next(wsig_q, wdata_q);
        wdata_d = LFSR_IN;
        addr_d  = last ? '0 : addr_q + ADDR_W'(1);
        we_d    = !last;
        state_d = last ? READ : WRITE;
      end
      READ: if (acc) begin
        rv_d   = 1'b1;
        rd_d   = MEM_RDATA;
        addr_d = last ? addr_q : addr_q + ADDR_W'(1);
        req_d  = !last;
      end else if (!req_q) begin
        state_d = CHECK;
      end
      CHECK: begin
        pass_d  = rsig_q == wsig_q;
        sig_d   = wsig_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
      wsig_q  <= '0;
      rsig_q  <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
      wsig_q  <= wsig_d;
      rsig_q  <= rsig_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end
  assign MEM_REQ   = req_q;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign SIG       = sig_q;
endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb_mem_bist_ctrl: directed table-driven bench for mem_bist_ctrl with DEPTH=4.
module tb_mem_bist_ctrl;
  logic CLK, RSTN, START, MEM_REQ, MEM_WE, MEM_ACK, BUSY, DONE, PASS, flip;
  logic [7:0] LFSR_IN, MEM_WDATA, MEM_RDATA, SIG;
  logic [1:0] MEM_ADDR;
  logic [7:0] mem [4];
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic       start;
    logic       req;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       pass;
  } row_t;
  row_t tab [11];
  mem_bist_ctrl #(.ADDR_W(2), .DEPTH(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .LFSR_IN(LFSR_IN),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .SIG(SIG)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) if (MEM_REQ && MEM_ACK && MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
  assign MEM_RDATA = mem[MEM_ADDR] ^ {7'b0, flip && MEM_ADDR == 2'd2};
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " req"}, 8'(MEM_REQ), 8'h0);
    chk({nm, " we"}, 8'(MEM_WE), 8'h0);
    chk({nm, " addr"}, 8'(MEM_ADDR), 8'h0);
    chk({nm, " wdata"}, MEM_WDATA, 8'h0);
    chk({nm, " busy"}, 8'(BUSY), 8'h0);
    chk({nm, " done"}, 8'(DONE), 8'h0);
    chk({nm, " pass"}, 8'(PASS), 8'h0);
    chk({nm, " sig"}, SIG, 8'h0);
  endtask
  // LFSR_IN presented before edge i is 17*(i+1): 11,22,33,44,55,...
  task automatic run_table(input string nm, input logic flip_i, input logic extra, input logic [7:0] sig0);
    flip = flip_i;
    for (int i = 0; i < 11; i++) begin
      START = tab[i].start | (extra && (i == 3 || i == 6));
      MEM_ACK = 1'b1;
      LFSR_IN = 8'((i + 1) * 17);
      @(posedge CLK);
      #1;
      chk($sformatf("%s e%0d req", nm, i), 8'(MEM_REQ), 8'(tab[i].req));
      chk($sformatf("%s e%0d we", nm, i), 8'(MEM_WE), 8'(tab[i].we));
      chk($sformatf("%s e%0d addr", nm, i), 8'(MEM_ADDR), 8'(tab[i].addr));
      chk($sformatf("%s e%0d wdata", nm, i), MEM_WDATA, tab[i].wdata);
      chk($sformatf("%s e%0d busy", nm, i), 8'(BUSY), 8'(tab[i].busy));
      chk($sformatf("%s e%0d done", nm, i), 8'(DONE), 8'(tab[i].done));
      chk($sformatf("%s e%0d pass", nm, i), 8'(PASS), 8'(tab[i].pass & !flip_i));
      chk($sformatf("%s e%0d sig", nm, i), SIG, i == 10 ? 8'h26 : sig0);
    end
    START = 1'b0;
  endtask
  initial begin
    tab[0]  = '{1, 1, 1, 2'd0, 8'h11, 1, 0, 0};
    tab[1]  = '{0, 1, 1, 2'd1, 8'h22, 1, 0, 0};
    tab[2]  = '{0, 1, 1, 2'd2, 8'h33, 1, 0, 0};
    tab[3]  = '{0, 1, 1, 2'd3, 8'h44, 1, 0, 0};
    tab[4]  = '{0, 1, 0, 2'd0, 8'h55, 1, 0, 0};
    tab[5]  = '{0, 1, 0, 2'd1, 8'h55, 1, 0, 0};
    tab[6]  = '{0, 1, 0, 2'd2, 8'h55, 1, 0, 0};
    tab[7]  = '{0, 1, 0, 2'd3, 8'h55, 1, 0, 0};
    tab[8]  = '{0, 0, 0, 2'd3, 8'h55, 1, 0, 0};
    tab[9]  = '{0, 0, 0, 2'd3, 8'h55, 1, 0, 0};
    tab[10] = '{0, 0, 0, 2'd3, 8'h55, 0, 1, 1};
    RSTN = 1'b0;
    START = 1'b0;
    MEM_ACK = 1'b1;
    LFSR_IN = 8'h0;
    flip = 1'b0;
    #2;
    chk_zero("reset");
    #10 RSTN = 1'b1;
    run_table("basic", 1'b0, 1'b0, 8'h00);
    run_table("flip", 1'b1, 1'b0, 8'h26);
    run_table("restart", 1'b0, 1'b1, 8'h26);
    flip = 1'b0;
    // Stall: ACK low on edges 2..4 while addr 1 is pending; writes 11,22,66,77.
    for (int e = 0; e < 14; e++) begin
      START = e == 0;
      MEM_ACK = !(e >= 2 && e <= 4);
      LFSR_IN = 8'((e + 1) * 17);
      @(posedge CLK);
      #1;
      if (e >= 1 && e <= 4) begin
        chk($sformatf("stall e%0d addr", e), 8'(MEM_ADDR), 8'h01);
        chk($sformatf("stall e%0d wdata", e), MEM_WDATA, 8'h22);
        chk($sformatf("stall e%0d req", e), 8'(MEM_REQ), 8'h01);
      end
      if (e == 12) chk("stall e12 done", 8'(DONE), 8'h00);
      if (e == 13) begin
        chk("stall e13 done", 8'(DONE), 8'h01);
        chk("stall e13 pass", 8'(PASS), 8'h01);
        chk("stall e13 sig", SIG, 8'hBE);
      end
    end
    // Reset during the read of addr 2 aborts everything at once.
    for (int e = 0; e < 7; e++) begin
      START = e == 0;
      MEM_ACK = 1'b1;
      LFSR_IN = 8'((e + 1) * 17);
      @(posedge CLK);
      #1;
    end
    START = 1'b0;
    chk("mid read addr", 8'(MEM_ADDR), 8'h02);
    #2 RSTN = 1'b0;
    #1;
    chk_zero("async reset");
    #3 RSTN = 1'b1;
    run_table("after reset", 1'b0, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, memory address width.
REQ-002 SHALL have parameter: DEPTH, 256, words tested (addresses 0..DEPTH-1); 2 <= DEPTH <= 2^ADDR_W.
REQ-003 SHALL have port: CLK  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: RSTN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port: START  in  1  begin test; sampled per edge.
REQ-006 SHALL have port: LFSR_IN  in  8  pseudo-random byte from the upstream 8-bit LFSR.
REQ-007 SHALL have port: MEM_REQ  out  1  memory request valid.
REQ-008 SHALL have port: MEM_WE  out  1  1=write, 0=read; valid with MEM_REQ.
REQ-009 SHALL have port: MEM_ADDR  out  ADDR_W  request address.
REQ-010 SHALL have port: MEM_WDATA  out  8  write data.
REQ-011 SHALL have port: MEM_ACK  in  1  memory accepts request; for reads MEM_RDATA is valid in the same cycle.
REQ-012 SHALL have port: MEM_RDATA  in  8  read data.
REQ-013 SHALL have port: BUSY  out  1  test in progress.
REQ-014 SHALL have port: DONE  out  1  test finished; held until next START.
REQ-015 SHALL have port: PASS  out  1  read signature equals write signature; meaningful only while DONE=1.
REQ-016 SHALL have port: SIG  out  8  final write signature.

Function
REQ-017 SHALL implement states IDLE, WRITE, READ, CHECK, FIN.
REQ-018 SHALL treat a transfer as complete on an edge where MEM_REQ=1 and MEM_ACK=1; MEM_ACK with MEM_REQ=0 is ignored.
REQ-019 SHALL hold MEM_WE, MEM_ADDR and MEM_WDATA stable while MEM_REQ=1 and MEM_ACK=0.
REQ-020 IDLE/FIN + START=1: clear both signatures, set MEM_ADDR=0, MEM_WE=1, MEM_REQ=1, latch MEM_WDATA<=LFSR_IN, set BUSY=1, clear DONE and PASS, then enter WRITE.
REQ-021 WRITE on a completed transfer: update the write signature with MEM_WDATA and latch MEM_WDATA<=LFSR_IN. If MEM_ADDR!=DEPTH-1, increment MEM_ADDR. Otherwise set MEM_ADDR=0 and MEM_WE=0, then enter READ.
REQ-022 READ on a completed transfer: update the read signature with MEM_RDATA. If MEM_ADDR!=DEPTH-1, increment MEM_ADDR. Otherwise drop MEM_REQ, then enter CHECK.
REQ-023 MEM_REQ SHALL stay high across back-to-back transfers, including the WRITE-to-READ switch; there are no idle cycles between transfers.
REQ-024 Signature update SHALL be sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ data, using 8-bit modulo arithmetic.
REQ-025 CHECK (one cycle): PASS <= (read sig == write sig), SIG <= write sig, DONE <= 1, BUSY <= 0, then enter FIN.
REQ-026 START SHALL be ignored in WRITE, READ and CHECK.
REQ-027 Latency: with MEM_ACK tied high, DONE SHALL rise on the edge 2*DEPTH+2 edges after the edge that sampled START. Each ACK-low cycle delays DONE by exactly one edge.
REQ-028 MEM_ADDR SHALL never exceed DEPTH-1; no wrap occurs beyond DEPTH-1.

Reset
REQ-029 RSTN=0 SHALL asynchronously force state=IDLE and set MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUSY, DONE, PASS, SIG and both signatures to 0.
REQ-030 Reset mid-test SHALL abort the test with no residual request. The first START after RSTN rises SHALL begin a fresh test.

Verification (DEPTH=4, ADDR_W=2, memory model: MEM_ACK=1, reads return last written byte)
REQ-031 START pulse at edge 0 -> writes to addr 0,1,2,3 on edges 1-4 and reads on edges 5-8; MEM_WDATA at each write equals LFSR_IN sampled on the previous accept edge (or the START edge); DONE=1, PASS=1, BUSY=0 at edge 10.
REQ-032 Model flips bit 0 of the read data at addr 2 -> DONE=1 at edge 10, PASS=0, SIG unchanged versus REQ-031.
REQ-033 MEM_ACK held low 3 cycles during the write of addr 1 -> MEM_ADDR=1 and MEM_WDATA constant through the stall; DONE at edge 13; PASS=1.
REQ-034 RSTN pulsed low during the read of addr 2 -> all outputs 0 immediately; START after release -> full test completes with PASS=1.
REQ-035 START re-asserted at edges 3 and 6 -> ignored, DONE timing unchanged; START in FIN -> DONE and PASS clear next edge and a new test begins.
